// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts ones over a window of 2^k accepted
// stream bits and reports the count scaled onto a 2^WIDTH full scale.
module sc_stream_decoder #(
   parameter int WIDTH = 13,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [LW-1:0]    len_log2,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   result
);

   typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

   localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

   state_t           state_r;
   logic [LW-1:0]    k_r;
   logic [WIDTH:0]   ones_r;
   logic [WIDTH:0]   samples_r;
   logic [WIDTH:0]   ones_next_s;
   logic [WIDTH:0]   last_sample_s;
   logic             terminal_s;

   // Window exponent is limited to 1..WIDTH so the window is never a single bit.
   function automatic logic [LW-1:0] clamp_k(input logic [LW-1:0] len);
      logic [LW-1:0] k;
      if (len == {LW{1'b0}}) begin
         k = {{(LW-1){1'b0}}, 1'b1};
      end else if (len > LW'(WIDTH)) begin
         k = LW'(WIDTH);
      end else begin
         k = len;
      end
      return k;
   endfunction

   // Next ones count and detection of the bit that completes the window.
   always_comb begin
      ones_next_s   = ones_r + {{WIDTH{1'b0}}, bit_in};
      last_sample_s = (ONE_W << k_r) - ONE_W;
      terminal_s    = 1'b0;
      if (bit_valid && (samples_r == last_sample_s)) begin
         terminal_s = 1'b1;
      end else begin
         terminal_s = 1'b0;
      end
   end

   // Control FSM with counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         k_r       <= {LW{1'b0}};
         ones_r    <= {(WIDTH+1){1'b0}};
         samples_r <= {(WIDTH+1){1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= {(WIDTH+1){1'b0}};
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start && !abort) begin
                  state_r   <= COUNT;
                  busy      <= 1'b1;
                  k_r       <= clamp_k(len_log2);
                  ones_r    <= {(WIDTH+1){1'b0}};
                  samples_r <= {(WIDTH+1){1'b0}};
               end
            end
            COUNT: begin
               // Abort takes priority over a terminal bit in the same cycle.
               if (abort) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (terminal_s) begin
                  result  <= ones_next_s << (LW'(WIDTH) - k_r);
                  done    <= 1'b1;
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (bit_valid) begin
                  samples_r <= samples_r + ONE_W;
                  ones_r    <= ones_next_s;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder: table of directed conversions,
// hand-written corner sequences, and random traffic against a queue-based model.
module tb_sc_stream_decoder;

   localparam int WIDTH = 13;
   localparam int LW    = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [LW-1:0]   len_log2 = '0;
   logic            bit_valid = 1'b0;
   logic            bit_in = 1'b0;
   logic            busy;
   logic            done;
   logic [WIDTH:0]  result;

   int checks = 0;
   int errors = 0;

   // reference model state: a conversion is a queue of accepted bits
   int m_busy = 0;
   int m_done = 0;
   int m_result = 0;
   int m_k = 0;
   int q[$];

   typedef struct {
      logic [LW-1:0] len;
      int            mode;
      bit            gap;
      int            exp_result;
      int            exp_lat;
   } vec_t;

   vec_t vecs[6];

   sc_stream_decoder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .len_log2(len_log2), .bit_valid(bit_valid), .bit_in(bit_in),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int s;
      m_done = 0;
      if (reset) begin
         m_busy = 0;
         m_result = 0;
         q.delete();
      end else if (m_busy == 0) begin
         if (start && !abort) begin
            m_busy = 1;
            m_k = (len_log2 == 0) ? 1 : ((int'(len_log2) > WIDTH) ? WIDTH : int'(len_log2));
            q.delete();
         end
      end else if (abort) begin
         m_busy = 0;
         q.delete();
      end else if (bit_valid) begin
         q.push_back(int'(bit_in));
         if (q.size() == (1 << m_k)) begin
            s = 0;
            foreach (q[i]) s += q[i];
            m_result = s * (1 << (WIDTH - m_k));
            m_done = 1;
            m_busy = 0;
            q.delete();
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("model_busy", int'(busy), m_busy);
      chk("model_done", int'(done), m_done);
      chk("model_result", int'(result), m_result);
   endtask

   function automatic logic bitgen(input int mode, input int idx);
      case (mode)
         0: return 1'b1;
         1: return (idx % 2) == 0;
         2: return 1'b0;
         3: return (idx % 3) == 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int bitrev13(input int c);
      int r = 0;
      for (int b = 0; b < WIDTH; b++) r = (r << 1) | ((c >> b) & 1);
      return r;
   endfunction

   task automatic run_conv(input logic [LW-1:0] len, input int mode, input bit gap,
                           input int exp_res, input int exp_lat);
      int lat = -1;
      int idx = 0;
      bit v;
      start = 1'b1; abort = 1'b0; len_log2 = len;
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      chk("start_busy", int'(busy), 1);
      for (int t = 1; t <= exp_lat + 4; t++) begin
         v = gap ? ((t % 2) == 0) : 1'b1;
         start = (t == 3);
         len_log2 = LW'($urandom_range(0, 15));
         bit_valid = v;
         bit_in = v ? bitgen(mode, idx) : 1'b1;
         tick();
         if (v) idx++;
         if (done) begin
            lat = t;
            break;
         end
      end
      chk("latency", lat, exp_lat);
      chk("result", int'(result), exp_res);
      chk("busy_in_done", int'(busy), 0);
      start = 1'b0; bit_valid = 1'b0;
      tick();
      chk("done_one_cycle", int'(done), 0);
   endtask

   task automatic exact(input int x);
      start = 1'b1; len_log2 = LW'(WIDTH); bit_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < (1 << WIDTH); c++) begin
         bit_valid = 1'b1;
         bit_in = (bitrev13(c) < x);
         tick();
      end
      chk("exact_done", int'(done), 1);
      chk("exact_result", int'(result), x);
      bit_valid = 1'b0;
      tick();
   endtask

   initial begin
      vecs[0] = '{len: 4'd13, mode: 0, gap: 1'b0, exp_result: 8192, exp_lat: 8192};
      vecs[1] = '{len: 4'd4,  mode: 1, gap: 1'b1, exp_result: 4096, exp_lat: 32};
      vecs[2] = '{len: 4'd0,  mode: 0, gap: 1'b0, exp_result: 8192, exp_lat: 2};
      vecs[3] = '{len: 4'd15, mode: 1, gap: 1'b0, exp_result: 4096, exp_lat: 8192};
      vecs[4] = '{len: 4'd2,  mode: 2, gap: 1'b0, exp_result: 0,    exp_lat: 4};
      vecs[5] = '{len: 4'd3,  mode: 3, gap: 1'b1, exp_result: 3072, exp_lat: 16};

      reset = 1'b1;
      tick();
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_result", int'(result), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_conv(vecs[i].len, vecs[i].mode, vecs[i].gap, vecs[i].exp_result, vecs[i].exp_lat);
      end

      exact(2560);
      exact(0);
      exact(8191);

      // abort after 100 bits keeps the previous result
      start = 1'b1; len_log2 = 4'd13; bit_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      abort = 1'b1;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_result", int'(result), 8191);
      abort = 1'b0;
      run_conv(4'd3, 0, 1'b0, 8192, 8);

      // abort together with start in IDLE
      start = 1'b1; abort = 1'b1; len_log2 = 4'd2;
      tick();
      chk("abort_start_busy", int'(busy), 0);
      start = 1'b0; abort = 1'b0; bit_valid = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("abort_start_idle", int'(busy), 0);
      chk("abort_start_nodone", int'(done), 0);

      // back-to-back k=2 conversions
      start = 1'b1; len_log2 = 4'd2; bit_valid = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1; bit_in = bitgen(1, i);
         tick();
      end
      chk("b2b_done1", int'(done), 1);
      chk("b2b_result1", int'(result), 4096);
      start = 1'b1; len_log2 = 4'd2; bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      chk("b2b_busy", int'(busy), 1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         tick();
      end
      chk("b2b_done2", int'(done), 1);
      chk("b2b_result2", int'(result), 8192);

      // reset mid-conversion
      start = 1'b1; len_log2 = 4'd13;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      tick();
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(done), 0);
      chk("midreset_result", int'(result), 0);
      reset = 1'b0;
      tick();

      // random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset     = ($urandom_range(0, 499) == 0);
         start     = ($urandom_range(0, 3) == 0);
         abort     = ($urandom_range(0, 39) == 0);
         len_log2  = LW'($urandom_range(0, 6));
         bit_valid = $urandom_range(0, 1);
         bit_in    = $urandom_range(0, 1);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
